// File: rtl/load_scoreboard_pkg.sv
// Opcode[6:2] classes and operand-validity decode shared by the load scoreboard
// and the X/M/W forwarding unit.
package load_scoreboard_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JAL      = 5'b11011;

  function automatic logic rs1_valid(input logic [4:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: rs1_valid = 1'b0;
      default:                     rs1_valid = 1'b1;
    endcase
  endfunction

  function automatic logic rs2_valid(input logic [4:0] opc);
    case (opc)
      OPC_BRANCH, OPC_OP, OPC_STORE: rs2_valid = 1'b1;
      default:                       rs2_valid = 1'b0;
    endcase
  endfunction

  function automatic logic rd_valid(input logic [4:0] opc, input logic [4:0] rd);
    case (opc)
      OPC_BRANCH, OPC_STORE: rd_valid = 1'b0;
      default:               rd_valid = (rd != 5'd0);
    endcase
  endfunction

endpackage

// File: rtl/load_scoreboard_sb_counter.sv
// Saturating up/down counter of loads in flight; flags a decrement attempted at zero.
module sb_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         underflow
);

  localparam logic [W-1:0] MAX_C = W'(MAX);
  localparam logic [W-1:0] ONE_C = W'(1);

  assign underflow = dec && (count == {W{1'b0}});

  // An unmatched decrement at zero is dropped, so it never cancels a real increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= {W{1'b0}};
    end else begin
      case ({inc, dec})
        2'b10: if (count != MAX_C) count <= count + ONE_C;
        2'b01: if (!underflow)     count <= count - ONE_C;
        2'b11: if (underflow)      count <= count + ONE_C;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/load_scoreboard.sv
// Decode-stage scoreboard for loads: tracks registers awaiting a memory response
// and stalls dependent instructions, full-queue loads and fences.
module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [6:0]       d_opcode,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic [4:0]       d_rd,
  input  logic             d_flush,
  input  logic             rsp_valid,
  input  logic [4:0]       rsp_rd,
  output logic             stall,
  output logic [CNT_W-1:0] outstanding,
  output logic             busy,
  output logic             sb_error
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

  // Bit 0 is kept at zero so x0 indexing never reports a hazard.
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic [4:0]  opc;
  logic        raw, waw, full, fence_wait;
  logic        issue, load_issue, underflow, rsp_stray;
  logic        unused_opc;

  assign opc        = d_opcode[6:2];
  assign unused_opc = &{1'b0, d_opcode[1:0]};

  // Hazard terms come from registered state only; no response-to-decode bypass.
  always_comb begin
    raw        = (rs1_valid(opc) && pending[d_rs1]) ||
                 (rs2_valid(opc) && pending[d_rs2]);
    waw        = rd_valid(opc, d_rd) && pending[d_rd];
    full       = (opc == OPC_LOAD) && (outstanding == MAX_C);
    fence_wait = (opc == OPC_MISC_MEM) && (outstanding != {CNT_W{1'b0}});
  end

  assign stall      = d_valid && !d_flush && (raw || waw || full || fence_wait);
  assign issue      = d_valid && !d_flush && !stall;
  assign load_issue = issue && (opc == OPC_LOAD);
  assign rsp_stray  = rsp_valid && (rsp_rd != 5'd0) && !pending[rsp_rd];
  assign busy       = (outstanding != {CNT_W{1'b0}});

  // Set and clear never target the same register in one cycle because waw blocks it.
  always_comb begin
    pending_next = pending;
    if (load_issue && (d_rd != 5'd0)) begin
      pending_next[d_rd] = 1'b1;
    end else begin
      pending_next = pending_next;
    end
    if (rsp_valid && (rsp_rd != 5'd0)) begin
      pending_next[rsp_rd] = 1'b0;
    end else begin
      pending_next = pending_next;
    end
    pending_next[0] = 1'b0;
  end

  // Pending-register vector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 32'd0;
    end else begin
      pending <= pending_next;
    end
  end

  // Sticky protocol-violation flag: unmatched or stray responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_error <= 1'b0;
    end else if (rsp_valid && (underflow || rsp_stray)) begin
      sb_error <= 1'b1;
    end
  end

  sb_counter #(
    .MAX (MAX_OUTSTANDING),
    .W   (CNT_W)
  ) u_counter (
    .clock     (clock),
    .reset     (reset),
    .inc       (load_issue),
    .dec       (rsp_valid),
    .count     (outstanding),
    .underflow (underflow)
  );

endmodule

// File: tb/tb_load_scoreboard.sv
// Scenario bench for load_scoreboard: per-cycle expectations are queued as stimulus
// is driven and popped when the outputs are sampled mid-cycle.
module tb_load_scoreboard;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ADD = 7'b0110011;
  localparam logic [6:0] FEN = 7'b0001111;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       d_valid = 1'b0;
  logic [6:0] d_opcode = 7'd0;
  logic [4:0] d_rs1 = 5'd0, d_rs2 = 5'd0, d_rd = 5'd0;
  logic       d_flush = 1'b0;
  logic       rsp_valid = 1'b0;
  logic [4:0] rsp_rd = 5'd0;
  logic       stall, busy, sb_error;
  logic [2:0] outstanding;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       r;
    logic       v;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       fl;
    logic       rv;
    logic [4:0] rrd;
    logic       es;
    logic [2:0] eo;
    logic       ee;
  } step_t;

  step_t exp_q[$];

  load_scoreboard #(.MAX_OUTSTANDING(4)) dut (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_opcode(d_opcode),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_flush(d_flush),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .stall(stall),
    .outstanding(outstanding), .busy(busy), .sb_error(sb_error)
  );

  always #5 clock = ~clock;

  function automatic step_t mk(logic r, logic v, logic [6:0] op, logic [4:0] rs1,
                               logic [4:0] rs2, logic [4:0] rd, logic fl, logic rv,
                               logic [4:0] rrd, logic es, logic [2:0] eo, logic ee);
    step_t s;
    s.r = r; s.v = v; s.op = op; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.fl = fl;
    s.rv = rv; s.rrd = rrd; s.es = es; s.eo = eo; s.ee = ee;
    return s;
  endfunction

  task automatic drive(step_t s);
    reset = s.r; d_valid = s.v; d_opcode = s.op; d_rs1 = s.rs1; d_rs2 = s.rs2;
    d_rd = s.rd; d_flush = s.fl; rsp_valid = s.rv; rsp_rd = s.rrd;
  endtask

  task automatic test_reset();
    step_t s[$];
    step_t e;
    s.push_back(mk(1, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, ADD,  2, 3, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, FEN,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clock); drive(s[i]); exp_q.push_back(s[i]);
      #1; e = exp_q.pop_front(); n_checks++;
      if ({stall, outstanding, busy, sb_error} !== {e.es, e.eo, e.eo != 3'd0, e.ee})
        $display("FAIL reset[%0d]: stall/outs/busy/err got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 i, stall, outstanding, busy, sb_error, e.es, e.eo, e.eo != 3'd0, e.ee);
      else n_pass++;
    end
  endtask

  task automatic test_raw();
    step_t s[$];
    step_t e;
    s.push_back(mk(1, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, LD,   1, 0, 5, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, ADD,  5, 1, 6, 0, 0, 0, 1, 1, 0));
    s.push_back(mk(0, 1, ADD,  5, 1, 6, 0, 0, 0, 1, 1, 0));
    s.push_back(mk(0, 1, ADD,  5, 1, 6, 0, 1, 5, 1, 1, 0));
    s.push_back(mk(0, 1, ADD,  5, 1, 6, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clock); drive(s[i]); exp_q.push_back(s[i]);
      #1; e = exp_q.pop_front(); n_checks++;
      if ({stall, outstanding, busy, sb_error} !== {e.es, e.eo, e.eo != 3'd0, e.ee})
        $display("FAIL raw[%0d]: stall/outs/busy/err got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 i, stall, outstanding, busy, sb_error, e.es, e.eo, e.eo != 3'd0, e.ee);
      else n_pass++;
    end
  endtask

  task automatic test_full();
    step_t s[$];
    step_t e;
    s.push_back(mk(1, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int r = 1; r <= 4; r++)
      s.push_back(mk(0, 1, LD, 10, 0, 5'(r), 0, 0, 0, 0, 3'(r - 1), 0));
    s.push_back(mk(0, 1, LD,   10, 0, 7, 0, 0, 0, 1, 4, 0));
    s.push_back(mk(0, 1, LD,   10, 0, 7, 0, 1, 2, 1, 4, 0));
    s.push_back(mk(0, 1, LD,   10, 0, 7, 0, 0, 0, 0, 3, 0));
    s.push_back(mk(0, 0, 7'd0, 0,  0, 0, 0, 0, 0, 0, 4, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clock); drive(s[i]); exp_q.push_back(s[i]);
      #1; e = exp_q.pop_front(); n_checks++;
      if ({stall, outstanding, busy, sb_error} !== {e.es, e.eo, e.eo != 3'd0, e.ee})
        $display("FAIL full[%0d]: stall/outs/busy/err got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 i, stall, outstanding, busy, sb_error, e.es, e.eo, e.eo != 3'd0, e.ee);
      else n_pass++;
    end
  endtask

  task automatic test_fence();
    step_t s[$];
    step_t e;
    s.push_back(mk(1, 0, 7'd0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, LD,   10, 0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, LD,   10, 0, 2, 0, 0, 0, 0, 1, 0));
    s.push_back(mk(0, 1, FEN,  0,  0, 0, 0, 0, 0, 1, 2, 0));
    s.push_back(mk(0, 1, FEN,  0,  0, 0, 0, 1, 1, 1, 2, 0));
    s.push_back(mk(0, 1, FEN,  0,  0, 0, 0, 1, 2, 1, 1, 0));
    s.push_back(mk(0, 1, FEN,  0,  0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 7'd0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clock); drive(s[i]); exp_q.push_back(s[i]);
      #1; e = exp_q.pop_front(); n_checks++;
      if ({stall, outstanding, busy, sb_error} !== {e.es, e.eo, e.eo != 3'd0, e.ee})
        $display("FAIL fence[%0d]: stall/outs/busy/err got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 i, stall, outstanding, busy, sb_error, e.es, e.eo, e.eo != 3'd0, e.ee);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    step_t e;
    s.push_back(mk(1, 0, 7'd0, 0,  0, 0,  0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, LD,   10, 0, 3,  0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, LD,   10, 0, 8,  0, 1, 3, 0, 1, 0));
    s.push_back(mk(0, 1, ADD,  8,  0, 11, 0, 0, 0, 1, 1, 0));
    s.push_back(mk(0, 1, ADD,  3,  3, 12, 0, 0, 0, 0, 1, 0));
    s.push_back(mk(0, 1, LD,   10, 0, 0,  0, 0, 0, 0, 1, 0));
    s.push_back(mk(0, 1, ADD,  0,  0, 13, 0, 0, 0, 0, 2, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clock); drive(s[i]); exp_q.push_back(s[i]);
      #1; e = exp_q.pop_front(); n_checks++;
      if ({stall, outstanding, busy, sb_error} !== {e.es, e.eo, e.eo != 3'd0, e.ee})
        $display("FAIL b2b[%0d]: stall/outs/busy/err got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 i, stall, outstanding, busy, sb_error, e.es, e.eo, e.eo != 3'd0, e.ee);
      else n_pass++;
    end
  endtask

  task automatic test_errors_flush();
    step_t s[$];
    step_t e;
    s.push_back(mk(1, 0, 7'd0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, LD,   10, 0, 4, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 7'd0, 0,  0, 0, 0, 1, 9, 0, 1, 0));
    s.push_back(mk(0, 1, ADD,  4,  0, 5, 0, 0, 0, 1, 0, 1));
    s.push_back(mk(0, 0, 7'd0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
    s.push_back(mk(1, 0, 7'd0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 7'd0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 7'd0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
    s.push_back(mk(0, 0, 7'd0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
    s.push_back(mk(1, 0, 7'd0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, LD,   10, 0, 5, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, ADD,  5,  1, 6, 1, 0, 0, 0, 1, 0));
    s.push_back(mk(0, 1, LD,   10, 0, 7, 1, 0, 0, 0, 1, 0));
    s.push_back(mk(0, 0, 7'd0, 0,  0, 0, 0, 0, 0, 0, 1, 0));
    s.push_back(mk(0, 1, ADD,  7,  1, 6, 0, 0, 0, 0, 1, 0));
    s.push_back(mk(0, 1, ADD,  5,  1, 6, 0, 0, 0, 1, 1, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clock); drive(s[i]); exp_q.push_back(s[i]);
      #1; e = exp_q.pop_front(); n_checks++;
      if ({stall, outstanding, busy, sb_error} !== {e.es, e.eo, e.eo != 3'd0, e.ee})
        $display("FAIL err_flush[%0d]: stall/outs/busy/err got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 i, stall, outstanding, busy, sb_error, e.es, e.eo, e.eo != 3'd0, e.ee);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    step_t e;
    @(negedge clock); drive(mk(1, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int r = 1; r <= 3; r++) begin
      @(negedge clock); drive(mk(0, 1, LD, 10, 0, 5'(r), 0, 0, 0, 0, 0, 0));
    end
    @(negedge clock); drive(mk(0, 1, ADD, 1, 2, 9, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 1, ADD, 1, 2, 9, 0, 0, 0, 1, 3, 0));
    #1; e = exp_q.pop_front(); n_checks++;
    if ({stall, outstanding, busy} !== {e.es, e.eo, 1'b1})
      $display("FAIL async_pre: stall/outs/busy got %b/%0d/%b want %b/%0d/1",
               stall, outstanding, busy, e.es, e.eo);
    else n_pass++;
    #1; reset = 1'b1;
    exp_q.push_back(mk(1, 1, ADD, 1, 2, 9, 0, 0, 0, 0, 0, 0));
    #1; e = exp_q.pop_front(); n_checks++;
    if ({stall, outstanding, busy, sb_error} !== {e.es, e.eo, 1'b0, e.ee})
      $display("FAIL async_clear: stall/outs/busy/err got %b/%0d/%b/%b want %b/%0d/0/%b",
               stall, outstanding, busy, sb_error, e.es, e.eo, e.ee);
    else n_pass++;
    @(negedge clock); drive(mk(0, 0, 7'd0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    @(negedge clock); drive(mk(0, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    #1; e = exp_q.pop_front(); n_checks++;
    if ({outstanding, busy, sb_error} !== {e.eo, 1'b0, e.ee})
      $display("FAIL async_stale: outs/busy/err got %0d/%b/%b want %0d/0/%b",
               outstanding, busy, sb_error, e.eo, e.ee);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raw();
    test_full();
    test_fence();
    test_back_to_back();
    test_errors_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
